// File: rtl/delay_seq_ctrl_if.sv
// delay_seq_ctrl_if: bundles the control/config inputs and the per-stage
// enable/ready signals of the power-up sequencer into one port.
// The master modport is the sequencer side. The slave modport is the
// surrounding system (config registers plus the downstream stages).
interface delay_seq_ctrl_if #(
  parameter int NUM_STAGES  = 4,
  parameter int DELAY_WIDTH = 9,
  parameter int TO_WIDTH    = 12
);
  localparam int CW = ($clog2(NUM_STAGES) > 1) ? $clog2(NUM_STAGES) : 1;

  logic                              enable;
  logic [NUM_STAGES*DELAY_WIDTH-1:0] delay_cfg;
  logic [TO_WIDTH-1:0]               rdy_timeout;
  logic [NUM_STAGES-1:0]             stage_rdy;
  logic [NUM_STAGES-1:0]             stage_en;
  logic                              done;
  logic                              busy;
  logic                              fault;
  logic [CW-1:0]                     cur_stage;

  modport master (
    input  enable, delay_cfg, rdy_timeout, stage_rdy,
    output stage_en, done, busy, fault, cur_stage
  );

  modport slave (
    output enable, delay_cfg, rdy_timeout, stage_rdy,
    input  stage_en, done, busy, fault, cur_stage
  );
endinterface

// File: rtl/delay_seq_ctrl.sv
// delay_seq_ctrl: brings up NUM_STAGES delay-gated resources in order.
// For each stage it waits a programmable delay, raises the stage enable,
// then waits for that stage's ready. Dropping enable tears the stages down
// from the highest stage to the lowest, one stage per cycle. If a ready
// that was already seen drops, all enables are cut and a sticky fault is
// raised.
// Build option: define DLYSEQ_TIMEOUT_EN to add a per-stage ready timeout
// (rdy_timeout cycles; 0 disables it). Without this macro, rdy_timeout is
// ignored and each stage waits for its ready indefinitely.
module delay_seq_ctrl #(
  parameter int NUM_STAGES  = 4,
  parameter int DELAY_WIDTH = 9,
  parameter int TO_WIDTH    = 12
) (
  input  logic             clk,
  input  logic             reset,
  delay_seq_ctrl_if.master sq
);
  localparam int CW    = ($clog2(NUM_STAGES) > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int CFG_W = NUM_STAGES * DELAY_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DLY,
    WAIT_RDY,
    UP,
    DOWN,
    FAULT
  } state_t;

  state_t                 state, state_nxt;
  logic [NUM_STAGES-1:0]  en_q, en_nxt;
  logic                   done_q, done_nxt;
  logic                   fault_q, fault_nxt;
  logic [CW-1:0]          cur_q, cur_nxt, cur_inc;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_nxt;
  logic [CFG_W-1:0]       dly_q, dly_nxt;
  logic                   lost_rdy;
  logic                   timeout_hit;
  logic                   cleared;

`ifdef DLYSEQ_TIMEOUT_EN
  logic [TO_WIDTH-1:0]    to_cnt_q, to_cnt_nxt;
  logic [TO_WIDTH-1:0]    to_lim_q, to_lim_nxt;

  // Ready timeout fires on the cycle the counter reaches the limit minus one
  always_comb begin
    timeout_hit = (state == WAIT_RDY) && (to_lim_q != '0) &&
                  !sq.stage_rdy[cur_q] &&
                  (to_cnt_q == (to_lim_q - TO_WIDTH'(1)));
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^sq.rdy_timeout;
  assign timeout_hit    = 1'b0;
`endif

  assign cur_inc = cur_q + CW'(1);

  // A stage counts as lost when its enable is high, its ready has already been seen, and the ready is now low
  always_comb begin
    lost_rdy = 1'b0;
    if ((state == WAIT_DLY) || (state == WAIT_RDY) || (state == UP)) begin
      for (int j = 0; j < NUM_STAGES; j++) begin
        if (en_q[j] && !sq.stage_rdy[j] && ((state == UP) || (j < int'(cur_q))))
          lost_rdy = 1'b1;
      end
    end
  end

  // Next-state and next-output logic: a fault wins over enable-low, which wins over normal progression
  always_comb begin
    state_nxt = state;
    en_nxt    = en_q;
    done_nxt  = done_q;
    fault_nxt = fault_q;
    cur_nxt   = cur_q;
    cnt_nxt   = cnt_q;
    dly_nxt   = dly_q;
    cleared   = 1'b0;
`ifdef DLYSEQ_TIMEOUT_EN
    to_cnt_nxt = to_cnt_q;
    to_lim_nxt = to_lim_q;
`endif

    case (state)
      IDLE: begin
        if (sq.enable) begin
          state_nxt = WAIT_DLY;
          cur_nxt   = '0;
          cnt_nxt   = sq.delay_cfg[DELAY_WIDTH-1:0];
          dly_nxt   = sq.delay_cfg;
`ifdef DLYSEQ_TIMEOUT_EN
          to_lim_nxt = sq.rdy_timeout;
          to_cnt_nxt = '0;
`endif
        end
      end

      WAIT_DLY, WAIT_RDY, UP: begin
        if (lost_rdy || timeout_hit) begin
          state_nxt = FAULT;
          en_nxt    = '0;
          done_nxt  = 1'b0;
          fault_nxt = 1'b1;
        end else if (!sq.enable) begin
          state_nxt = DOWN;
          done_nxt  = 1'b0;
        end else if (state == WAIT_DLY) begin
          if (cnt_q != '0) begin
            cnt_nxt = cnt_q - DELAY_WIDTH'(1);
          end else begin
            en_nxt[cur_q] = 1'b1;
            state_nxt     = WAIT_RDY;
`ifdef DLYSEQ_TIMEOUT_EN
            to_cnt_nxt = '0;
`endif
          end
        end else if (state == WAIT_RDY) begin
          if (sq.stage_rdy[cur_q]) begin
            if (cur_q == LAST) begin
              done_nxt  = 1'b1;
              state_nxt = UP;
            end else begin
              cur_nxt   = cur_inc;
              cnt_nxt   = dly_q[int'(cur_inc)*DELAY_WIDTH +: DELAY_WIDTH];
              state_nxt = WAIT_DLY;
            end
          end
`ifdef DLYSEQ_TIMEOUT_EN
          if (!sq.stage_rdy[cur_q] && (to_lim_q != '0) && (to_cnt_q != '1))
            to_cnt_nxt = to_cnt_q + TO_WIDTH'(1);
`endif
        end
      end

      DOWN: begin
        if (en_q == '0) begin
          state_nxt = IDLE;
        end else begin
          for (int j = NUM_STAGES - 1; j >= 0; j--) begin
            if (en_q[j] && !cleared) begin
              en_nxt[j] = 1'b0;
              cleared   = 1'b1;
            end
          end
        end
      end

      FAULT: begin
        en_nxt    = '0;
        done_nxt  = 1'b0;
        fault_nxt = 1'b1;
        if (!sq.enable) begin
          state_nxt = IDLE;
          fault_nxt = 1'b0;
          cur_nxt   = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      en_q    <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      cur_q   <= '0;
      cnt_q   <= '0;
      dly_q   <= '0;
`ifdef DLYSEQ_TIMEOUT_EN
      to_cnt_q <= '0;
      to_lim_q <= '0;
`endif
    end else begin
      state   <= state_nxt;
      en_q    <= en_nxt;
      done_q  <= done_nxt;
      fault_q <= fault_nxt;
      cur_q   <= cur_nxt;
      cnt_q   <= cnt_nxt;
      dly_q   <= dly_nxt;
`ifdef DLYSEQ_TIMEOUT_EN
      to_cnt_q <= to_cnt_nxt;
      to_lim_q <= to_lim_nxt;
`endif
    end
  end

  assign sq.stage_en  = en_q;
  assign sq.done      = done_q;
  assign sq.fault     = fault_q;
  assign sq.cur_stage = cur_q;
  assign sq.busy      = (state != IDLE);
endmodule

// File: doc/delay_seq_ctrl.md
Name: delay_seq_ctrl

Overview:
- Multi-stage power-up/bring-up sequencer for resources gated by delay lines (PLL/PHY/reset release chains).
- Asserts NUM_STAGES enables in order. Each stage waits a programmable delay, then waits for that stage's ready.
- Disable tears stages down in reverse order. Fault detection covers lost ready and ready timeout.
- Sits between top-level enable/config registers and the per-stage enable inputs of downstream blocks.

Parameters:
- NUM_STAGES, 4, number of sequenced stages (min 2).
- DELAY_WIDTH, 9, per-stage delay counter width.
- TO_WIDTH, 12, ready-timeout counter width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- enable  input  1  level request: high = bring up, low = tear down
- delay_cfg  input  NUM_STAGES*DELAY_WIDTH  per-stage delay in cycles; stage i at bits [i*DELAY_WIDTH +: DELAY_WIDTH]
- rdy_timeout  input  TO_WIDTH  max cycles to wait for stage_rdy; 0 = no timeout
- stage_rdy  input  NUM_STAGES  per-stage ready status
- stage_en  output  NUM_STAGES  per-stage enable (registered)
- done  output  1  all stages up (registered)
- busy  output  1  state != IDLE
- fault  output  1  sticky fault flag (registered)
- cur_stage  output  max(1,$clog2(NUM_STAGES))  index of stage being sequenced

Behaviour:
- Clock/reset: one clock. Reset is asynchronous and active-high.
- Reset values: state=IDLE, stage_en=0, done=0, fault=0, cur_stage=0, internal counters=0.
- Delay snapshot: delay_cfg and rdy_timeout are captured on the IDLE->WAIT_DLY edge. Changes mid-sequence have no effect.
- IDLE:
  - enable sampled high at edge T0 -> WAIT_DLY, cur_stage<=0, cnt<=delay[0].
- WAIT_DLY:
  - Each edge: if cnt!=0 then cnt<=cnt-1.
  - Else stage_en[cur_stage]<=1, to_cnt<=0, -> WAIT_RDY.
  - Stage 0 enable goes high at edge T0+delay[0]+1; delay 0 gives 1 cycle.
- WAIT_RDY, on stage_rdy[cur_stage] sampled high:
  - If cur_stage==NUM_STAGES-1: done<=1 and -> UP.
  - Else cur_stage<=cur_stage+1, cnt<=delay[cur_stage+1], -> WAIT_DLY.
  - Next enable therefore rises delay+1 cycles after the ready edge.
- UP: hold. done=1, all stage_en=1.
- Lost-ready fault:
  - Condition: in WAIT_DLY, WAIT_RDY or UP, stage_rdy[j] is low for any j whose stage_en[j]=1 and j<cur_stage (or any j in UP).
  - Action: -> FAULT, stage_en<=0 (all, same edge), done<=0, fault<=1.
- FAULT:
  - Outputs held at stage_en=0, fault=1.
  - enable low -> IDLE with fault<=0, cur_stage<=0.
- Tear-down (enable low in WAIT_DLY, WAIT_RDY or UP):
  - -> DOWN, done<=0.
  - In DOWN, each edge clears the highest set stage_en bit, one bit per cycle.
  - When stage_en==0 -> IDLE.
  - Tear-down takes popcount(stage_en)+1 cycles.
  - No fault checks in DOWN.
- enable re-asserted during DOWN: ignored; DOWN completes, then IDLE restarts on the next sample.
- Priority when events coincide on one edge: fault > enable-low > ready/delay progression.
- Width rules: counters saturate at 0, no wrap. cur_stage never exceeds NUM_STAGES-1.

Optional Feature:
- Macro: DLYSEQ_TIMEOUT_EN.
- Defined:
  - In WAIT_RDY with rdy_timeout!=0, to_cnt increments each cycle stage_rdy[cur_stage] is low.
  - When to_cnt==rdy_timeout-1 and ready is still low: -> FAULT, stage_en<=0, fault<=1.
  - rdy_timeout==0 disables the timeout.
- Undefined:
  - Timeout counter and compare logic are not built. rdy_timeout is ignored.
  - WAIT_RDY waits indefinitely. Only lost-ready faults occur.

Test Plan:
- Delays {3,0,5,1}, stage_rdy tied to stage_en delayed 2 cycles:
  - enable rises at T0 -> stage_en[0] rises at T0+4.
  - Each later stage rises delay+1 cycles after its ready.
  - done rises the edge stage_rdy[3] is seen. busy=1 throughout.
- From UP, drop enable:
  - stage_en goes 1111->0111->0011->0001->0000 on consecutive edges.
  - busy falls one cycle later. done=0 on the first edge.
- In UP, pull stage_rdy[1] low for 1 cycle:
  - Next edge: stage_en=0000, fault=1, done=0.
  - Fault holds while enable stays high. Clears the edge after enable low, with state IDLE.
- With DLYSEQ_TIMEOUT_EN, rdy_timeout=10, stage_rdy[2] stuck low:
  - fault=1 exactly 10 cycles after stage_en[2] rose.
  - Without the macro: no fault after 5000 cycles.
- Assert reset asynchronously mid-WAIT_DLY at stage 2:
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release with enable high, the sequence restarts from stage 0.
- Change delay_cfg[0] from 3 to 50 two cycles after start: stage_en[0] still rises at T0+4.
